// File: rtl/tanh_rr_sched.sv
// Round-robin scheduler sharing one combinational tanh unit among N_REQ requesters.
// One operation in flight; x is held SETTLE_CYC cycles before y is sampled.
module tanh_rr_sched #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned X_W        = 16,
  parameter int unsigned Y_W        = 32,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*X_W-1:0]       req_x,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [Y_W-1:0]             rsp_y,
  output logic [X_W-1:0]             tanh_x,
  input  logic [Y_W-1:0]             tanh_y,
  output logic                       busy,
  output logic [15:0]                op_cnt
);

  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0]  id, id_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ID_W-1:0]  grant, sel;
  logic             grant_vld;
  logic [X_W-1:0]   x_sel;
  logic [X_W-1:0]   tanh_x_nxt;
  logic             rsp_valid_nxt;
  logic [ID_W-1:0]  rsp_id_nxt;
  logic [Y_W-1:0]   rsp_y_nxt;
  logic [15:0]      op_cnt_nxt;
  logic             busy_nxt;

  // First valid requester found searching upward from rr_ptr, modulo N_REQ.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    sel       = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sel = ID_W'((32'(rr_ptr) + k) % N_REQ);
      if (!grant_vld && req_valid[sel]) begin
        grant     = sel;
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    x_sel     = '0;
    req_ready = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant == ID_W'(i)) x_sel = req_x[i*X_W +: X_W];
      req_ready[i] = (state == IDLE) && grant_vld && (grant == ID_W'(i));
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    id_nxt        = id;
    cnt_nxt       = cnt;
    tanh_x_nxt    = tanh_x;
    rsp_valid_nxt = rsp_valid;
    rsp_id_nxt    = rsp_id;
    rsp_y_nxt     = rsp_y;
    op_cnt_nxt    = op_cnt;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          tanh_x_nxt = x_sel;
          id_nxt     = grant;
          rr_ptr_nxt = ID_W'((32'(grant) + 32'd1) % N_REQ);
          cnt_nxt    = CNT_W'(SETTLE_CYC - 1);
          state_nxt  = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          rsp_y_nxt     = tanh_y;
          rsp_id_nxt    = id;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RESP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          op_cnt_nxt    = op_cnt + 16'd1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id        <= '0;
      cnt       <= '0;
      tanh_x    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
      op_cnt    <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      id        <= id_nxt;
      cnt       <= cnt_nxt;
      tanh_x    <= tanh_x_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_id    <= rsp_id_nxt;
      rsp_y     <= rsp_y_nxt;
      op_cnt    <= op_cnt_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_tanh_rr_sched.sv
// Directed bench for tanh_rr_sched; a table-driven stand-in plays the tanh unit.
module tb_tanh_rr_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_x;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_y;
  logic [15:0] tanh_x;
  logic [31:0] tanh_y;
  logic        busy;
  logic [15:0] op_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // tanh(1.7)*4096 = 3831.4 -> 0x0EF7; tanh(-8)*4096 = -4095.999 -> 0xF000 (sign-extended)
  function automatic logic [31:0] tanh_unit(input logic [15:0] x);
    case (x)
      16'h1B33: tanh_unit = 32'h0000_0EF7;
      16'h0000: tanh_unit = 32'h0000_0000;
      16'h8000: tanh_unit = 32'hFFFF_F000;
      default:  tanh_unit = {16'hA5A5, x};
    endcase
  endfunction

  assign tanh_y = tanh_unit(tanh_x);

  tanh_rr_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .tanh_x(tanh_x), .tanh_y(tanh_y), .busy(busy), .op_cnt(op_cnt)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; req_x = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (req_ready != 4'b0000) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_rsp(output logic ok, output int lat);
    ok  = 1'b0;
    lat = 0;
    for (int n = 0; n < 30; n++) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL reset_idle cycle=%0d busy=%b rsp_valid=%b req_ready=%b want 0/0/0000",
                 c, busy, rsp_valid, req_ready);
      end
      @(negedge clk);
      #1;
    end
    checks++;
    if (tanh_x !== 16'h0 || rsp_id !== 2'd0 || rsp_y !== 32'h0 || op_cnt !== 16'h0) begin
      failures++;
      $display("FAIL reset_values tanh_x=%h rsp_id=%0d rsp_y=%h op_cnt=%h want all zero",
               tanh_x, rsp_id, rsp_y, op_cnt);
    end
  endtask

  task automatic test_single();
    logic ok;
    int   lat;
    do_reset();
    req_x[2*16 +: 16] = 16'h1B33;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL single_ready got=%b want=0100", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    checks++;
    if (tanh_x !== 16'h1B33 || busy !== 1'b1 || req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL single_settle tanh_x=%h busy=%b req_ready=%b want 1b33/1/0000",
               tanh_x, busy, req_ready);
    end
    wait_rsp(ok, lat);
    checks++;
    if (!ok || lat != 4) begin
      failures++;
      $display("FAIL single_latency ok=%b lat=%0d want lat=4", ok, lat);
    end
    checks++;
    if (rsp_id !== 2'd2 || rsp_y !== 32'h0000_0EF7) begin
      failures++;
      $display("FAIL single_rsp id=%0d y=%h want 2/00000ef7", rsp_id, rsp_y);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || op_cnt !== 16'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done rsp_valid=%b op_cnt=%0d busy=%b want 0/1/0",
               rsp_valid, op_cnt, busy);
    end
  endtask

  task automatic test_round_robin();
    logic       ok;
    int         lat;
    logic [3:0] exp_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] exp_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req_x     = '0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      wait_ready(ok);
      checks++;
      if (!ok || req_ready !== exp_rdy[g]) begin
        failures++;
        $display("FAIL rr_grant%0d ok=%b req_ready=%b want %b", g, ok, req_ready, exp_rdy[g]);
      end
      @(negedge clk);
      if (g == 4) req_valid = 4'b0000;
      #1;
      wait_rsp(ok, lat);
      checks++;
      if (!ok || rsp_id !== exp_id[g] || rsp_y !== 32'h0) begin
        failures++;
        $display("FAIL rr_rsp%0d ok=%b id=%0d y=%h want %0d/0", g, ok, rsp_id, rsp_y, exp_id[g]);
      end
      @(negedge clk);
      #1;
    end
    checks++;
    if (op_cnt !== 16'd5 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rr_opcnt op_cnt=%0d busy=%b want 5/0", op_cnt, busy);
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    int   lat;
    do_reset();
    req_x[1*16 +: 16] = 16'h1B33;
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    wait_ready(ok);
    checks++;
    if (!ok || req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL bp_grant ok=%b req_ready=%b want 0010", ok, req_ready);
    end
    @(negedge clk);
    req_valid = 4'b1000;
    #1;
    wait_rsp(ok, lat);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bp_rsp_timeout lat=%0d want rsp_valid", lat);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_y !== 32'h0000_0EF7 ||
          req_ready !== 4'b0000 || tanh_x !== 16'h1B33) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d v=%b id=%0d y=%h rdy=%b x=%h want 1/1/00000ef7/0000/1b33",
                 c, rsp_valid, rsp_id, rsp_y, req_ready, tanh_x);
      end
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || op_cnt !== 16'd1 || tanh_x !== 16'h1B33) begin
      failures++;
      $display("FAIL bp_release v=%b op_cnt=%0d x=%h want 0/1/1b33", rsp_valid, op_cnt, tanh_x);
    end
  endtask

  task automatic test_mid_reset();
    logic ok;
    do_reset();
    req_x[3*16 +: 16] = 16'h1B33;
    req_valid = 4'b1000;
    rsp_ready = 1'b1;
    #1;
    wait_ready(ok);
    checks++;
    if (!ok || req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL mr_grant ok=%b req_ready=%b want 1000", ok, req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || tanh_x !== 16'h0) begin
      failures++;
      $display("FAIL mr_async busy=%b rsp_valid=%b tanh_x=%h want 0/0/0000", busy, rsp_valid, tanh_x);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL mr_no_rsp cycle=%0d rsp_valid=%b busy=%b want 0/0", c, rsp_valid, busy);
      end
    end
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL mr_next_grant req_ready=%b want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
  endtask

  task automatic test_wrap_negative();
    logic ok;
    int   lat;
    do_reset();
    force dut.op_cnt = 16'hFFFF;
    #1;
    release dut.op_cnt;
    req_x[0 +: 16] = 16'h8000;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    wait_ready(ok);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    wait_rsp(ok, lat);
    checks++;
    if (!ok || rsp_id !== 2'd0 || rsp_y !== 32'hFFFF_F000 || tanh_x !== 16'h8000) begin
      failures++;
      $display("FAIL neg_rsp ok=%b id=%0d y=%h x=%h want 0/fffff000/8000", ok, rsp_id, rsp_y, tanh_x);
    end
    @(negedge clk);
    #1;
    checks++;
    if (op_cnt !== 16'h0000) begin
      failures++;
      $display("FAIL opcnt_wrap got=%h want 0000", op_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_x = '0; rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
    test_wrap_negative();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
